ienc: RTL
=========

# ienc

Debug instruction encoder for the fpga64 CPU: it turns high-level command requests into 32-bit MIPS III instruction words and streams them to the instruction-injection port of the fetch stage. It performs the inverse of the register-fetch decoder, going from operation and register fields to an opcode word. Constant loads expand into multi-word LUI/ORI/DSLL sequences, so the block is a small sequencer with a valid/ready handshake on both sides.

## Interface
- Parameters: none.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- reqvalid  in  1  command request valid
- reqready  out  1  command can be accepted; equals (state == IDLE)
- reqop  in  4  command code (see Operation)
- reqrs  in  5  source register rs
- reqrt  in  5  register rt (source or target)
- reqrd  in  5  destination register rd
- reqimm  in  64  immediate; commands 2–5 use bits [15:0], LI32 uses [31:0], LI64 uses [63:0]
- instrvalid  out  1  instr holds a valid word
- instrready  in  1  downstream accepts instr
- instr  out  32  encoded instruction word (registered)
- seqlast  out  1  instr is the final word of the current command
- busy  out  1  command in progress (state != IDLE)
- err  out  1  one-cycle pulse on acceptance of an undefined reqop

## Operation
- Request accepted on reqvalid & reqready. reqop, reqrs, reqrt, reqrd and reqimm are latched at acceptance. Request inputs are ignored at all other times.
- Command codes and emitted words, in order:
  - 0 NOP: 0x00000000.
  - 1 ADDU: 000000|rs|rt|rd|00000|100001.
  - 2 LW: 100011|rs|rt|imm[15:0].
  - 3 SW: 101011|rs|rt|imm[15:0].
  - 4 LD: 110111|rs|rt|imm[15:0].
  - 5 SD: 111111|rs|rt|imm[15:0].
  - 6 LI32, 2 words: LUI rt, imm[31:16] (001111|00000|rt|imm16); then ORI rt, rt, imm[15:0] (001101|rt|rt|imm16).
  - 7 LI64, 6 words:
    - LUI rt, imm[63:48]
    - ORI rt, rt, imm[47:32]
    - DSLL rt, rt, 16 (000000|00000|rt|rt|10000|111000)
    - ORI rt, rt, imm[31:16]
    - DSLL rt, rt, 16
    - ORI rt, rt, imm[15:0]
  - 8–15 undefined: emit a single NOP word and pulse err in the cycle after acceptance.
- rt = 0 is not special-cased; words are encoded as given.
- States:
  - IDLE → EMIT on acceptance, with word index = 0.
  - In EMIT: if instrvalid & instrready and index == last, go to IDLE; otherwise index increments.
  - Word count per command: 1, except LI32 = 2 and LI64 = 6.
- seqlast = instrvalid & (index == last).
- Reset values: state IDLE, index 0, instr 0x00000000, instrvalid 0, seqlast 0, busy 0, err 0. reqready is 1 while and after reset.
- Reset mid-command aborts the command. instrvalid drops asynchronously, no further words are emitted, and the latched command is discarded.

## Timing
- Acceptance at edge N: instrvalid = 1 with word 0 from edge N onward, i.e. visible in cycle N+1.
- instr and seqlast are stable while instrvalid = 1 and instrready = 0. No word changes without a handshake.
- After a word handshake at edge M, the next word of the same command is visible after edge M, giving zero-bubble streaming.
- Last-word handshake at edge M: instrvalid = 0 and reqready = 1 after M. The earliest next acceptance is edge M+1, with its first word at M+2.
- Throughput:
  - Single-word commands: one every 2 cycles with instrready held high.
  - LI64: 6 words in 6 consecutive cycles.
- instrready while instrvalid = 0 is ignored.

## Test plan
- ADDU rs=1, rt=2, rd=3 → single word 0x00221821, seqlast = 1, reqready returns 1 the cycle after the handshake.
- LW rs=29, rt=5, imm=0x0010 → 0x8FA50010. SW with the same fields → 0xAFA50010.
- LI32 rt=8, imm=0x12345678 → 0x3C081234, then 0x35085678. seqlast only on the second word. reqready is 0 throughout.
- LI64 rt=8, imm=0x0123456789ABCDEF, instrready high → 0x3C080123, 0x35084567, 0x00084438, 0x350889AB, 0x00084438, 0x3508CDEF on 6 consecutive cycles.
- LI32 as above with instrready low for 3 cycles on word 0 → instr holds 0x3C081234 with instrvalid = 1 for all 3 cycles, then proceeds normally. A reqvalid pulse during this interval is not accepted.
- Reset asserted after word 2 of LI64 → instrvalid, busy and seqlast go to 0 immediately, reqready = 1. A new NOP request afterwards yields exactly 0x00000000. Also: reqop=15 → 0x00000000 with a one-cycle err pulse.

Source files
------------

// File: rtl/ienc_if.sv
// Command-request and instruction-stream bundle for the ienc debug instruction encoder.
interface ienc_if;
  logic        reqvalid;
  logic        reqready;
  logic [3:0]  reqop;
  logic [4:0]  reqrs;
  logic [4:0]  reqrt;
  logic [4:0]  reqrd;
  logic [63:0] reqimm;
  logic        instrvalid;
  logic        instrready;
  logic [31:0] instr;
  logic        seqlast;
  logic        busy;
  logic        err;

  modport master (
    output reqvalid, reqop, reqrs, reqrt, reqrd, reqimm, instrready,
    input  reqready, instrvalid, instr, seqlast, busy, err
  );

  modport slave (
    input  reqvalid, reqop, reqrs, reqrt, reqrd, reqimm, instrready,
    output reqready, instrvalid, instr, seqlast, busy, err
  );
endinterface

// File: rtl/ienc.sv
// Debug instruction encoder: expands high-level commands into MIPS III words
// (including LUI/ORI/DSLL constant-load sequences) on a valid/ready stream.
module ienc (
  input  logic   clk,
  input  logic   rst,
  ienc_if.slave  bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  rs_q, rs_d;
  logic [4:0]  rt_q, rt_d;
  logic [4:0]  rd_q, rd_d;
  logic [63:0] imm_q, imm_d;
  logic [31:0] instr_q, instr_d;
  logic        instrvalid_q, instrvalid_d;
  logic        seqlast_q, seqlast_d;
  logic        err_q, err_d;

  logic        accept;
  logic        hs;
  logic [2:0]  idx_nxt;

  function automatic logic [2:0] last_idx(input logic [3:0] op);
    case (op)
      4'd6:    return 3'd1;
      4'd7:    return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] lui(input logic [4:0] rt, input logic [15:0] h);
    return {6'b001111, 5'd0, rt, h};
  endfunction

  function automatic logic [31:0] ori(input logic [4:0] rt, input logic [15:0] h);
    return {6'b001101, rt, rt, h};
  endfunction

  function automatic logic [31:0] encode(input logic [3:0] op, input logic [2:0] idx,
                                         input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [63:0] imm);
    case (op)
      4'd1: return {6'b000000, rs, rt, rd, 5'd0, 6'b100001};
      4'd2: return {6'b100011, rs, rt, imm[15:0]};
      4'd3: return {6'b101011, rs, rt, imm[15:0]};
      4'd4: return {6'b110111, rs, rt, imm[15:0]};
      4'd5: return {6'b111111, rs, rt, imm[15:0]};
      4'd6: return (idx == 3'd0) ? lui(rt, imm[31:16]) : ori(rt, imm[15:0]);
      4'd7:
        case (idx)
          3'd0:       return lui(rt, imm[63:48]);
          3'd1:       return ori(rt, imm[47:32]);
          3'd2, 3'd4: return {6'b000000, 5'd0, rt, rt, 5'b10000, 6'b111000};
          3'd3:       return ori(rt, imm[31:16]);
          default:    return ori(rt, imm[15:0]);
        endcase
      default: return '0;
    endcase
  endfunction

  assign accept  = bus.reqvalid & (state_q == IDLE);
  assign hs      = instrvalid_q & bus.instrready;
  assign idx_nxt = idx_q + 3'd1;

  // Next word is encoded one step ahead so instr is registered and streams without bubbles.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    op_d         = op_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    imm_d        = imm_q;
    instr_d      = instr_q;
    instrvalid_d = instrvalid_q;
    seqlast_d    = seqlast_q;
    err_d        = 1'b0;
    if (accept) begin
      state_d      = EMIT;
      idx_d        = '0;
      op_d         = bus.reqop;
      rs_d         = bus.reqrs;
      rt_d         = bus.reqrt;
      rd_d         = bus.reqrd;
      imm_d        = bus.reqimm;
      instr_d      = encode(bus.reqop, 3'd0, bus.reqrs, bus.reqrt, bus.reqrd, bus.reqimm);
      instrvalid_d = 1'b1;
      seqlast_d    = (last_idx(bus.reqop) == 3'd0);
      err_d        = bus.reqop[3];
    end else if (hs) begin
      if (idx_q == last_idx(op_q)) begin
        state_d      = IDLE;
        instrvalid_d = 1'b0;
        seqlast_d    = 1'b0;
      end else begin
        idx_d     = idx_nxt;
        instr_d   = encode(op_q, idx_nxt, rs_q, rt_q, rd_q, imm_q);
        seqlast_d = (idx_nxt == last_idx(op_q));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      op_q         <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      imm_q        <= '0;
      instr_q      <= '0;
      instrvalid_q <= 1'b0;
      seqlast_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      op_q         <= op_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      imm_q        <= imm_d;
      instr_q      <= instr_d;
      instrvalid_q <= instrvalid_d;
      seqlast_q    <= seqlast_d;
      err_q        <= err_d;
    end
  end

  assign bus.reqready   = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.instrvalid = instrvalid_q;
  assign bus.instr      = instr_q;
  assign bus.seqlast    = seqlast_q;
  assign bus.err        = err_q;

endmodule
